readback_arbiter: RTL

Shares the single 10-bit crate readback byte link between three readback sources: the counter readback block, the history-FIFO dump and the status block. It arbitrates the sources' requests round-robin and issues the one-cycle `rd` strobe to the winner. It forwards that source's byte stream, registered, onto the link and enforces a start timeout and an inter-record gap. It sits between the readback sources and the crate link serializer.

---
 rtl/readback_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/readback_arbiter.sv
// Round-robin arbiter that hands the crate readback byte link to one of three
// sources per record, forwarding the winner's byte stream with a start timeout and inter-record gap.
module readback_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int GAP     = 4
) (
    input  logic        clk16,
    input  logic        reset_n,
    input  logic [2:0]  req,
    input  logic [2:0]  src_read,
    input  logic [9:0]  src_byt0,
    input  logic [9:0]  src_byt1,
    input  logic [9:0]  src_byt2,
    output logic [2:0]  rd,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic        link_valid,
    output logic [9:0]  link_byte,
    output logic [15:0] rec_count,
    output logic [7:0]  to_count
);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_STROBE, S_WAIT, S_XFER, S_GAP} state_e;

    state_e      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [2:0]  rd_q, rd_d;
    logic        busy_q, busy_d;
    logic        link_valid_q, link_valid_d;
    logic [9:0]  link_byte_q, link_byte_d;
    logic [15:0] rec_count_q, rec_count_d;
    logic [7:0]  to_count_q, to_count_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [3:0]  gcnt_q, gcnt_d;

    logic [1:0]  cand0, cand1, pick;
    logic [3:0]  req_x;
    logic        sel_read;
    logic [9:0]  sel_byt;

    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s >= 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // Search starts just after the last winner, so the last winner ranks lowest.
    always_comb begin
        req_x = {1'b0, req};
        cand0 = next_src(gnt_q);
        cand1 = next_src(cand0);
        if (req_x[cand0])      pick = cand0;
        else if (req_x[cand1]) pick = cand1;
        else                   pick = gnt_q;
    end

    always_comb begin
        case (gnt_q)
            2'd0:    begin sel_read = src_read[0]; sel_byt = src_byt0; end
            2'd1:    begin sel_read = src_read[1]; sel_byt = src_byt1; end
            default: begin sel_read = src_read[2]; sel_byt = src_byt2; end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        tcnt_d       = tcnt_q;
        gcnt_d       = gcnt_q;
        rec_count_d  = rec_count_q;
        to_count_d   = to_count_q;
        rd_d         = 3'b000;
        link_valid_d = 1'b0;
        link_byte_d  = 10'h000;
        case (state_q)
            S_IDLE: begin
                if (req != 3'b000) begin
                    gnt_d   = pick;
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                rd_d    = 3'b001 << gnt_q;
                tcnt_d  = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A read arriving on the timeout cycle still counts as a start.
                if (sel_read) begin
                    state_d = S_XFER;
                end else if (tcnt_q == TO_LAST) begin
                    if (to_count_q != 8'hff) to_count_d = to_count_q + 8'd1;
                    gcnt_d  = 4'd0;
                    state_d = S_GAP;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_XFER: begin
                if (sel_read) begin
                    link_valid_d = 1'b1;
                    link_byte_d  = sel_byt;
                end else begin
                    rec_count_d = rec_count_q + 16'd1;
                    gcnt_d      = 4'd0;
                    state_d     = S_GAP;
                end
            end
            S_GAP: begin
                if (gcnt_q == GAP_LAST) state_d = S_IDLE;
                else                    gcnt_d  = gcnt_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            gnt_q        <= 2'd2;
            rd_q         <= 3'b000;
            busy_q       <= 1'b0;
            link_valid_q <= 1'b0;
            link_byte_q  <= 10'h000;
            rec_count_q  <= 16'd0;
            to_count_q   <= 8'd0;
            tcnt_q       <= 8'd0;
            gcnt_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rd_q         <= rd_d;
            busy_q       <= busy_d;
            link_valid_q <= link_valid_d;
            link_byte_q  <= link_byte_d;
            rec_count_q  <= rec_count_d;
            to_count_q   <= to_count_d;
            tcnt_q       <= tcnt_d;
            gcnt_q       <= gcnt_d;
        end
    end

    assign rd         = rd_q;
    assign gnt        = gnt_q;
    assign busy       = busy_q;
    assign link_valid = link_valid_q;
    assign link_byte  = link_byte_q;
    assign rec_count  = rec_count_q;
    assign to_count   = to_count_q;
endmodule
